// File: rtl/dsp_imem_loader_pkg.sv
// Shared constants for the DSP instruction memory and its loader.
// Fetch, decode and the loader take their widths and sizes from here so they agree.
package dsp_imem_loader_pkg;

  localparam int unsigned InstWordLen = 32;
  localparam int unsigned MemAddrLen  = 16;
  localparam int unsigned ImemDepth   = 256;
  localparam int unsigned NopWord     = 0;

  // Loader FSM encoding
  localparam logic StIdle = 1'b0;
  localparam logic StLoad = 1'b1;

endpackage

// File: rtl/dsp_imem_ram.sv
// DEPTH x WIDTH instruction array: synchronous write, asynchronous read.
module dsp_imem_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port; contents are never cleared so unwritten words survive reloads
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dsp_imem_loader.sv
// Instruction memory with a byte-serial program loader. The core is held in
// reset while a load is running, so fetch restarts from address 0 afterwards.
module dsp_imem_loader
  import dsp_imem_loader_pkg::*;
#(
  parameter int unsigned       INST_W   = InstWordLen,
  parameter int unsigned       ADDR_W   = MemAddrLen,
  parameter int unsigned       DEPTH    = ImemDepth,
  parameter logic [INST_W-1:0] NOP_WORD = INST_W'(NopWord)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_addr_i,
  output logic [INST_W-1:0] read_data_o,
  input  logic              load_start_i,
  input  logic              load_valid_i,
  input  logic [7:0]        load_byte_i,
  input  logic              load_last_i,
  output logic              load_ready_o,
  output logic              load_done_o,
  output logic              load_overflow_o,
  output logic              core_hold_o
);

  localparam int unsigned BPW = INST_W / 8;
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW  = $clog2(DEPTH + 1);
  localparam int unsigned CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic              state_q, state_d;
  logic [CW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [PW-1:0]     word_ptr_q, word_ptr_d;
  logic [INST_W-1:0] asm_q, asm_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic              accept;
  logic              word_end;
  logic              mem_we;
  logic [INST_W-1:0] shifted;
  logic [INST_W-1:0] wr_word;
  logic [INST_W-1:0] ram_rdata;
  logic              read_ok;

  // A byte presented alongside load_start is dropped by the restart
  assign accept   = (state_q == StLoad) && load_valid_i && !load_start_i;
  assign shifted  = (asm_q << 8) | INST_W'(load_byte_i);
  assign word_end = accept && (load_last_i || (byte_cnt_q == CW'(BPW - 1)));
  // Left-align a short final word so its missing low bytes read as zero
  assign wr_word  = shifted << ((int'(BPW) - 1 - int'(byte_cnt_q)) * 8);

  // Loader FSM, byte assembly and word pointer next-state
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_ptr_d = word_ptr_q;
    asm_d      = asm_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    mem_we     = 1'b0;
    if (load_start_i) begin
      state_d    = StLoad;
      byte_cnt_d = '0;
      word_ptr_d = '0;
      asm_d      = '0;
      ovf_d      = 1'b0;
    end else if (accept) begin
      if (word_end) begin
        asm_d      = '0;
        byte_cnt_d = '0;
        if (word_ptr_q < PW'(DEPTH)) begin
          mem_we     = 1'b1;
          word_ptr_d = word_ptr_q + 1'b1;
        end else begin
          ovf_d = 1'b1;  // pointer saturates at DEPTH
        end
      end else begin
        asm_d      = shifted;
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
      if (load_last_i) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end
  end

  // Loader state registers; synchronous reset leaves the memory untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      word_ptr_q <= '0;
      asm_q      <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_ptr_q <= word_ptr_d;
      asm_q      <= asm_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  dsp_imem_ram #(
    .WIDTH (INST_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (word_ptr_q[AW-1:0]),
    .wdata_i (wr_word),
    .raddr_i (read_addr_i[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  // Full-width range check so high address bits cannot alias into the array
  assign read_ok     = (state_q == StIdle) && (64'(read_addr_i) < 64'(DEPTH));
  assign read_data_o = read_ok ? ram_rdata : NOP_WORD;

  assign core_hold_o     = (state_q == StLoad);
  assign load_ready_o    = (state_q == StLoad);
  assign load_done_o     = done_q;
  assign load_overflow_o = ovf_q;

endmodule

// File: tb/tb_dsp_imem_loader.sv
// Self-checking bench for dsp_imem_loader: a byte-level model pushes written
// words to a scoreboard that is drained through the read port after load_done.
module tb_dsp_imem_loader;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH  = 16;
  localparam logic [31:0] NOP    = 32'h0;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] read_addr_i;
  logic [INST_W-1:0] read_data_o;
  logic              load_start_i;
  logic              load_valid_i;
  logic [7:0]        load_byte_i;
  logic              load_last_i;
  logic              load_ready_o;
  logic              load_done_o;
  logic              load_overflow_o;
  logic              core_hold_o;

  always #5 clk = ~clk;

  dsp_imem_loader #(
    .INST_W   (INST_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .read_addr_i     (read_addr_i),
    .read_data_o     (read_data_o),
    .load_start_i    (load_start_i),
    .load_valid_i    (load_valid_i),
    .load_byte_i     (load_byte_i),
    .load_last_i     (load_last_i),
    .load_ready_o    (load_ready_o),
    .load_done_o     (load_done_o),
    .load_overflow_o (load_overflow_o),
    .core_hold_o     (core_hold_o)
  );

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] exp_mem [DEPTH];
  logic        exp_known [DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          hold_cnt = 0;

  // Reference model state
  logic        m_load;
  int          m_cnt;
  logic [31:0] m_asm;
  int          m_ptr;
  logic        m_ovf;
  logic        m_done;

  task automatic model_reset();
    m_load = 1'b0; m_cnt = 0; m_asm = '0; m_ptr = 0; m_ovf = 1'b0; m_done = 1'b0;
  endtask

  // One clock cycle of load-port stimulus, then check the control outputs
  task automatic cyc(input logic st, input logic v, input logic l, input logic [7:0] b,
                     input string tag);
    logic [31:0] word;
    load_start_i = st; load_valid_i = v; load_last_i = l; load_byte_i = b;
    m_done = 1'b0;
    if (st) begin
      m_load = 1'b1; m_cnt = 0; m_asm = '0; m_ptr = 0; m_ovf = 1'b0;
    end else if (m_load && v) begin
      m_asm = {m_asm[23:0], b};
      m_cnt++;
      if (m_cnt == 4 || l) begin
        word = m_asm << (8 * (4 - m_cnt));
        if (m_ptr < int'(DEPTH)) begin
          sb_q.push_back('{addr: 4'(m_ptr), data: word});
          exp_mem[m_ptr]   = word;
          exp_known[m_ptr] = 1'b1;
          m_ptr++;
        end else begin
          m_ovf = 1'b1;
        end
        m_cnt = 0; m_asm = '0;
      end
      if (l) begin
        m_load = 1'b0; m_done = 1'b1;
      end
    end
    @(posedge clk); #1;
    load_start_i = 1'b0; load_valid_i = 1'b0; load_last_i = 1'b0; load_byte_i = 8'h00;
    if (core_hold_o) hold_cnt++;
    n_checks += 4;
    if (core_hold_o !== m_load) begin
      n_fail++; $display("FAIL %s core_hold: got %b expected %b", tag, core_hold_o, m_load);
    end
    if (load_ready_o !== m_load) begin
      n_fail++; $display("FAIL %s load_ready: got %b expected %b", tag, load_ready_o, m_load);
    end
    if (load_done_o !== m_done) begin
      n_fail++; $display("FAIL %s load_done: got %b expected %b", tag, load_done_o, m_done);
    end
    if (load_overflow_o !== m_ovf) begin
      n_fail++;
      $display("FAIL %s load_overflow: got %b expected %b", tag, load_overflow_o, m_ovf);
    end
  endtask

  // Wait (bounded) for load_done, then pop every queued word and read it back
  task automatic wait_done_drain(input string tag);
    sb_t e;
    for (int i = 0; i < 4 && load_done_o !== 1'b1; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, tag);
    n_checks++;
    if (load_done_o !== 1'b1) begin
      n_fail++; $display("FAIL %s done_timeout: got %b expected 1", tag, load_done_o);
    end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      read_addr_i = ADDR_W'(e.addr);
      #1;
      n_checks++;
      if (read_data_o !== e.data) begin
        n_fail++;
        $display("FAIL %s mem[%0d]: got %h expected %h", tag, e.addr, read_data_o, e.data);
      end
    end
    read_addr_i = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    n_checks += 4;
    if (core_hold_o !== 1'b0) begin n_fail++; $display("FAIL reset core_hold: got %b expected 0", core_hold_o); end
    if (load_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset load_ready: got %b expected 0", load_ready_o); end
    if (load_done_o !== 1'b0) begin n_fail++; $display("FAIL reset load_done: got %b expected 0", load_done_o); end
    if (load_overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset overflow: got %b expected 0", load_overflow_o); end
  endtask

  task automatic test_basic();
    logic [7:0] bytes [8];
    bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    hold_cnt = 0;
    cyc(1'b1, 1'b0, 1'b0, 8'h00, "basic");
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "basic");
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, (i == 7), bytes[i], "basic");
    n_checks++;
    if (hold_cnt !== 9) begin
      n_fail++; $display("FAIL basic hold_cycles: got %0d expected 9", hold_cnt);
    end
    read_addr_i = 16'd1; #1;
    n_checks++;
    if (read_data_o !== 32'hAABBCCDD) begin
      n_fail++; $display("FAIL basic read1: got %h expected aabbccdd", read_data_o);
    end
    wait_done_drain("basic");
  endtask

  task automatic test_partial();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, "partial");
    for (int i = 1; i <= 5; i++) cyc(1'b0, 1'b1, (i == 5), 8'(i), "partial");
    read_addr_i = 16'd1; #1;
    n_checks++;
    if (read_data_o !== 32'h05000000) begin
      n_fail++; $display("FAIL partial pad: got %h expected 05000000", read_data_o);
    end
    wait_done_drain("partial");
  endtask

  task automatic test_overflow();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, "ovf");
    for (int i = 0; i < 68; i++) cyc(1'b0, 1'b1, (i == 67), 8'(i + 8'h40), "ovf");
    n_checks++;
    if (load_overflow_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf sticky: got %b expected 1", load_overflow_o);
    end
    wait_done_drain("ovf");
    // A fresh start clears the sticky flag
    cyc(1'b1, 1'b0, 1'b0, 8'h00, "ovf_clear");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, (i == 3), 8'(8'h90 + i), "ovf_clear");
    wait_done_drain("ovf_clear");
  endtask

  task automatic test_gaps_restart();
    logic [7:0] b1 [7];
    b1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    cyc(1'b1, 1'b0, 1'b0, 8'h00, "gaps");
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b1, (i == 6), b1[i], "gaps");
      if (i < 2) cyc(1'b0, 1'b0, 1'b0, 8'hFF, "gaps");
    end
    wait_done_drain("gaps");
    cyc(1'b1, 1'b0, 1'b0, 8'h00, "restart");
    cyc(1'b0, 1'b1, 1'b0, 8'h01, "restart");
    cyc(1'b0, 1'b1, 1'b0, 8'h02, "restart");
    cyc(1'b1, 1'b1, 1'b0, 8'hEE, "restart");
    cyc(1'b0, 1'b1, 1'b0, 8'h88, "restart");
    cyc(1'b0, 1'b1, 1'b0, 8'h99, "restart");
    cyc(1'b0, 1'b1, 1'b0, 8'hAA, "restart");
    cyc(1'b0, 1'b1, 1'b1, 8'hBB, "restart");
    read_addr_i = 16'd0; #1;
    n_checks++;
    if (read_data_o !== 32'h8899AABB) begin
      n_fail++; $display("FAIL restart addr0: got %h expected 8899aabb", read_data_o);
    end
    wait_done_drain("restart");
  endtask

  task automatic test_read_guard();
    logic [15:0] bad [3];
    bad = '{16'h0010, 16'h0101, 16'hFFFF};
    for (int i = 0; i < 3; i++) begin
      read_addr_i = bad[i]; #1;
      n_checks++;
      if (read_data_o !== NOP) begin
        n_fail++; $display("FAIL guard range %h: got %h expected %h", bad[i], read_data_o, NOP);
      end
    end
    read_addr_i = '0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 8'h5A, "guard_idle");
    for (int a = 0; a < int'(DEPTH); a++) begin
      read_addr_i = 16'(a); #1;
      if (exp_known[a]) begin
        n_checks++;
        if (read_data_o !== exp_mem[a]) begin
          n_fail++; $display("FAIL guard idle mem[%0d]: got %h expected %h", a, read_data_o, exp_mem[a]);
        end
      end
    end
    read_addr_i = '0;
    @(posedge clk); #1;
    cyc(1'b1, 1'b0, 1'b0, 8'h00, "guard_load");
    #1;
    n_checks++;
    if (read_data_o !== NOP) begin
      n_fail++; $display("FAIL guard in_load: got %h expected %h", read_data_o, NOP);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, (i == 3), 8'(8'hB0 + i), "guard_load");
    wait_done_drain("guard_load");
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, "rst_mid");
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'hC1 + i), "rst_mid");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    n_checks += 3;
    if (core_hold_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid core_hold: got %b expected 0", core_hold_o); end
    if (load_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid load_ready: got %b expected 0", load_ready_o); end
    if (load_done_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid load_done: got %b expected 0", load_done_o); end
    read_addr_i = 16'd1; #1;
    n_checks++;
    if (read_data_o !== exp_mem[1]) begin
      n_fail++; $display("FAIL rst_mid mem[1]: got %h expected %h", read_data_o, exp_mem[1]);
    end
    // load_done never comes after an abort; read back the word written before reset
    while (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      read_addr_i = ADDR_W'(e.addr); #1;
      n_checks++;
      if (read_data_o !== e.data) begin
        n_fail++; $display("FAIL rst_mid mem[%0d]: got %h expected %h", e.addr, read_data_o, e.data);
      end
    end
    read_addr_i = '0;
  endtask

  initial begin
    rst = 1'b1; read_addr_i = '0;
    load_start_i = 1'b0; load_valid_i = 1'b0; load_last_i = 1'b0; load_byte_i = 8'h00;
    for (int i = 0; i < int'(DEPTH); i++) begin exp_mem[i] = '0; exp_known[i] = 1'b0; end
    model_reset();
    test_reset();
    test_basic();
    test_partial();
    test_overflow();
    test_gaps_restart();
    test_read_guard();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_imem_loader.md
# dsp_imem_loader

Instruction memory for the DSP core: the responder on the fetch read port. Fetch drives a word address and samples the returned instruction in the same cycle. A byte-serial load port writes the program into the memory. While a load is in progress, the block holds the core in reset, so fetch restarts at address 0 once the load completes.

## Interface
- INST_W, `` `INST_WORD_LEN ``, instruction word width in bits; multiple of 8.
- ADDR_W, `` `MEM_ADDR_LEN ``, fetch address width.
- DEPTH, 256, number of instruction words stored.
- NOP_WORD, 0, value returned for invalid reads.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- read_addr  in  ADDR_W  word address from fetch.
- read_data  out  INST_W  instruction word back to fetch; combinational.
- load_start  in  1  one-cycle pulse; begins a new program load.
- load_valid  in  1  load_byte is valid this cycle.
- load_byte  in  8  program byte; most-significant byte of each word first.
- load_last  in  1  qualifies the final byte of the program.
- load_ready  out  1  block accepts a byte this cycle.
- load_done  out  1  one-cycle pulse when a load completes.
- load_overflow  out  1  sticky; program exceeded DEPTH words.
- core_hold  out  1  drives the core's reset input; high while loading.

## Operation
- BPW = INST_W/8 bytes per word.
- States are IDLE and LOAD.
- **IDLE**
  - core_hold=0, load_ready=0.
  - load_valid is ignored.
  - load_start → LOAD.
- **LOAD**
  - core_hold=1, load_ready=1.
  - A byte is accepted when load_valid & load_ready.
  - An accepted byte shifts into the assembly register (left shift by 8, new byte into the LSBs) and increments byte_cnt.
  - When byte_cnt reaches BPW-1 on an accepted byte, the completed word is written to mem[word_ptr] at that clock edge. word_ptr then increments and byte_cnt returns to 0.
- **load_last**
  - Ends the load when the byte carrying it is accepted.
  - If the word is incomplete, the remaining low bytes are zero-padded and the word is written.
  - State → IDLE and load_done=1 on the following cycle.
- **load_start while in LOAD**: restarts the load. word_ptr=0, byte_cnt=0, the assembly register is cleared, load_overflow is cleared, and any byte presented that cycle is dropped.
- **Overflow**: a word write with word_ptr ≥ DEPTH is discarded and load_overflow is set. The load otherwise continues to load_last. word_ptr saturates at DEPTH.
- **Memory contents**: locations not rewritten keep their previous contents. A new load does not clear memory.
- **Read port**
  - read_data = mem[read_addr] when state=IDLE and read_addr < DEPTH.
  - Otherwise read_data = NOP_WORD.
  - read_addr bits above log2(DEPTH) must be checked, not truncated.

## Timing
- Reset values:
  - state=IDLE, core_hold=0, load_ready=0, load_done=0, load_overflow=0.
  - word_ptr=0, byte_cnt=0.
  - Memory is not cleared.
- Read latency: 0 cycles; read_data is combinational from read_addr. Fetch registers the PC, so there is no loop.
- load_start in cycle N: core_hold=1 and load_ready=1 from cycle N+1.
- Throughput: one byte per cycle, no stall. The word write happens on the same edge that accepts the last byte of the word.
- Last byte accepted in cycle M:
  - In cycle M+1: core_hold=0, load_ready=0, load_done=1, and read_data is valid from the new contents.
  - Fetch leaves reset and reads address 0 at M+1.
- rst mid-load: the load is aborted and the state returns to IDLE. Words already written remain in memory. A partial assembly word is lost.
- load_overflow stays set until the next load_start or rst.

## Structure
- INST_WORD_LEN and MEM_ADDR_LEN come from the shared `definitions.v`. Add `IMEM_DEPTH` and `NOP_WORD` there so that fetch, decode and this block agree.
- One sub-module is natural: `dsp_imem_ram`, a DEPTH×INST_W array with a synchronous write port and an asynchronous read port.
- The FSM, byte assembly and pointers live in the top level.

## Test plan
Bench parameters: INST_W=32, DEPTH=16.

1. **Basic load.** load_start, then bytes 12 34 56 78 AA BB CC DD with load_last on DD, one per cycle.
   - Required: mem[0]=0x12345678, mem[1]=0xAABBCCDD.
   - load_done pulses one cycle after DD; core_hold is high for exactly 9 cycles.
   - Reading address 1 then returns 0xAABBCCDD combinationally.
2. **Partial word.** 5 bytes 01 02 03 04 05 with load_last on 05.
   - Required: mem[1]=0x05000000, mem[0]=0x01020304.
3. **Overflow.** 17 words are loaded.
   - Required: mem[0..15] hold words 0–15, word 16 is dropped, load_overflow=1.
   - A new load_start clears load_overflow.
4. **Gaps and restart.** load_valid toggles 1-0-1, then load_start arrives mid-word.
   - Required: gap cycles do not advance byte_cnt.
   - After the restart, the first full word lands at address 0, and the byte presented with load_start is dropped.
5. **Read guarding.**
   - read_addr=16 in IDLE, and read_addr=0 while in LOAD: read_data=NOP_WORD.
   - load_valid in IDLE: no memory change.
6. **Reset mid-load.** rst after 6 bytes.
   - Required: next cycle state=IDLE, core_hold=0, mem[0] keeps the word completed before reset, mem[1] is unchanged.
